text_screen_ctrl: RTL
=====================

# text_screen_ctrl

Sequencer for the full-screen 16x16 character text layers: the start-screen and end-screen character ROMs. It owns the screen FSM (START → PLAY → END → START) and selects which ROM's `char_code` reaches the character drawer. It applies a per-frame "typewriter" reveal and a blinking prompt row to that code. It sits between the `draw_char` address generator (which supplies `char_xy`), the two `char_rom_16x16_*` instances, and the font ROM lookup.

## Interface
Parameters:
- `REVEAL_FRAMES`, default 2: frames per newly revealed character (≥1).
- `BLINK_FRAMES`, default 30: frames per blink half-period of the prompt row (≥1).

Ports:
- `clk`  in  1: pixel clock; the block's only clock.
- `rst`  in  1: reset, synchronous, active-high.
- `vblnk`  in  1: vertical blank level from the timing chain. Its rising edge is the frame tick.
- `start_btn`  in  1: debounced start button level. The block edge-detects it internally.
- `game_over`  in  1: single-cycle pulse from game logic.
- `char_xy`  in  8: character cell address from `draw_char`, {row[3:0], col[3:0]}.
- `code_start`  in  7: start-screen ROM output for `char_xy` (combinational).
- `code_end`  in  7: end-screen ROM output for `char_xy` (combinational).
- `char_code`  out  7: code to the font ROM, registered.
- `text_en`  out  1: text layer visible, registered.
- `game_active`  out  1: high while in PLAY, registered.
- `screen`  out  2: current `screen_t` state.

## Operation
- FSM states are `SCR_START`, `SCR_PLAY` and `SCR_END`. Reset enters `SCR_START`.
- Frame tick: `vblnk` is high now and was low in the previous cycle.
- Start press: `start_btn` is high now and was low in the previous cycle.
- On every transition into `SCR_START` or `SCR_END`:
  - `reveal_cnt` (9 bit, 0..256) clears to 0.
  - The reveal frame divider clears.
  - The blink phase is set to 1 and its divider clears.
- Reveal:
  - While `reveal_cnt` < 256, it increments once every `REVEAL_FRAMES` frame ticks.
  - It saturates at 256 ("revealed").
- Blink: the blink phase toggles every `BLINK_FRAMES` frame ticks, in START and END only.
- Code selection, evaluated in this priority order:
  - PLAY → `Spc`.
  - `char_xy` ≥ `reveal_cnt` → `Spc`.
  - Row 0xF (`char_xy[7:4]`==4'hF) with blink phase 0 → `Spc`.
  - Otherwise the ROM code for the current screen (START → `code_start`, END → `code_end`).
- Transitions:
  - START, start press, not revealed: `reveal_cnt` jumps to 256 (skip). State is unchanged.
  - START, start press, revealed: go to PLAY.
  - PLAY, `game_over`: go to END. `start_btn` is ignored in PLAY.
  - END, start press, not revealed: skip to 256.
  - END, start press, revealed: go to START.
  - `game_over` outside PLAY is ignored.
- `text_en` = 1 in START and END, 0 in PLAY.
- `game_active` = 1 exactly in PLAY.

## Timing
- Reset values: `char_code` = `Spc`, `text_en` = 0, `game_active` = 0, `screen` = `SCR_START`, `reveal_cnt` = 0, blink phase = 1, both edge-detector history flops = 0.
- Latency: `char_xy`/`code_*` → `char_code` is exactly 1 cycle. `draw_char` delays its pixel pipeline by 1 cycle to match.
- State change is visible on `screen`/`text_en`/`game_active` 1 cycle after the triggering press or pulse.
- The first `char_code` under the new state appears on the same edge as the state change.
- Frame tick and start press in the same cycle:
  - The press is evaluated against the pre-tick `reveal_cnt`.
  - If the press causes a skip, the skip wins (256).
- Transitioning into START/END clears counters on that edge. A frame tick in that same cycle is discarded.
- `game_over` and a start press in the same cycle while in PLAY: go to END.
- `rst` mid-operation: all registers return to their reset values on that edge regardless of state. The next press is detected only after a fresh low→high on `start_btn`.
- A `start_btn` held high across reset does not generate a press until it falls and rises again.

## Structure
- `vga_pkg` gains:
  - `typedef enum logic [1:0] {SCR_START, SCR_PLAY, SCR_END} screen_t`.
  - The existing `Spc` character constant, used for blanking.
- One sub-module, `frame_divider` (parameter `N`):
  - Inputs: `clk`, `rst`, `clr`, `tick_in`. Output: `tick_out`.
  - Pulses `tick_out` on every Nth `tick_in` after `clr`.
  - Instantiated twice, for reveal and blink.
- Rising-edge detection for `vblnk` and `start_btn` stays inline.

## Test plan
- Reset, `REVEAL_FRAMES`=2, drive 2 frame ticks:
  - `reveal_cnt`=1.
  - `char_xy`=0x00 → `char_code`=`code_start` one cycle later.
  - `char_xy`=0x01 → `Spc`.
  - `text_en`=1, `game_active`=0.
- After 1 frame tick in START, press start:
  - Reveal skips; `char_xy`=0x03 returns `code_start`.
  - `screen` stays START.
  - A second press → `screen`=PLAY, `game_active`=1, `text_en`=0, `char_code`=`Spc` for any `char_xy`.
- In PLAY, pulse `game_over` and press start in the same cycle:
  - `screen`=END, `reveal_cnt`=0.
  - After skip, `char_xy`=0x10 returns `code_end`, not `code_start`.
- Revealed START, `BLINK_FRAMES`=30, `char_xy`=0xF5:
  - `code_start` for ticks 0–29.
  - `Spc` for ticks 30–59.
  - `code_start` again at tick 60.
  - `char_xy`=0x25 is unaffected throughout.
- Hold `start_btn` high through reset and 5 frames: no skip, no transition. Release, then press: skip occurs.
- Assert `rst` for 1 cycle while in END mid-reveal:
  - Next cycle `screen`=START, `char_code`=`Spc`, `text_en`=0.
  - One cycle later `text_en`=1 and `reveal_cnt`=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA/text-layer definitions.
//   screen_t    : screen sequencer state (start screen, gameplay, end screen).
//   Spc         : font ROM code of the blank (space) character, used for blanking.
//   REVEAL_DONE : reveal counter value meaning "every cell of the 16x16 grid shown".
package vga_pkg;

    typedef enum logic [1:0] {
        SCR_START,
        SCR_PLAY,
        SCR_END
    } screen_t;

    localparam logic [6:0] Spc         = 7'h20;
    localparam logic [8:0] REVEAL_DONE = 9'd256;

    // True for the screens that show a full-screen text layer.
    function automatic logic is_text_screen(input screen_t s);
        return (s == SCR_START) || (s == SCR_END);
    endfunction

endpackage

// File: rtl/text_screen_ctrl_frame_divider.sv
// frame_divider: divides a stream of single-cycle ticks by N.
//   clk      : clock
//   rst      : synchronous active-high reset
//   clr      : synchronous clear of the divider count (takes priority over tick_in)
//   tick_in  : input tick (one cycle wide)
//   tick_out : combinational pulse coincident with every Nth tick_in after clr/rst
module frame_divider #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick_in,
    output logic tick_out
);

    localparam int            W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0]  LAST = W'(N - 1);

    logic [W-1:0] cnt_reg;

    // A tick arriving together with clr is swallowed, so the caller never sees
    // a stale pulse on the edge where it restarts the division.
    assign tick_out = tick_in && !clr && (cnt_reg == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg <= '0;
        end else if (tick_in) begin
            cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/text_screen_ctrl.sv
// text_screen_ctrl: sequences the START -> PLAY -> END -> START screens and
// produces the character code for the full-screen 16x16 text layers, with a
// per-frame typewriter reveal and a blinking prompt row (row 0xF).
//   clk         : pixel clock
//   rst         : synchronous active-high reset
//   vblnk       : vertical blank level; rising edge = frame tick
//   start_btn   : debounced start button level (edge-detected here)
//   game_over   : single-cycle pulse from game logic
//   char_xy     : {row, col} cell address from draw_char
//   code_start  : start-screen ROM code for char_xy
//   code_end    : end-screen ROM code for char_xy
//   char_code   : registered code to the font ROM (1-cycle latency from char_xy)
//   text_en     : registered text layer enable
//   game_active : registered, high while in PLAY
//   screen      : current screen state
module text_screen_ctrl
    import vga_pkg::*;
#(
    parameter int REVEAL_FRAMES = 2,
    parameter int BLINK_FRAMES  = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblnk,
    input  logic       start_btn,
    input  logic       game_over,
    input  logic [7:0] char_xy,
    input  logic [6:0] code_start,
    input  logic [6:0] code_end,
    output logic [6:0] char_code,
    output logic       text_en,
    output logic       game_active,
    output screen_t    screen
);

    logic       vblnk_prev_reg;
    logic       start_prev_reg;
    logic       start_armed_reg;
    screen_t    screen_reg;
    logic [8:0] reveal_cnt_reg;
    logic       blink_reg;
    logic [6:0] char_code_reg;
    logic       text_en_reg;
    logic       game_active_reg;

    screen_t    screen_next;
    logic [8:0] reveal_cnt_next;
    logic       blink_next;
    logic [6:0] char_code_next;
    logic       skip;
    logic       enter_text;

    logic       frame_tick;
    logic       start_press;
    logic       revealed;
    logic       text_tick;
    logic       reveal_tick;
    logic       blink_tick;

    assign frame_tick  = vblnk && !vblnk_prev_reg;
    // The armed flag stays low after reset until the button is seen released,
    // so a button held through reset cannot produce a press.
    assign start_press = start_btn && !start_prev_reg && start_armed_reg;
    assign revealed    = (reveal_cnt_reg == REVEAL_DONE);
    // Reveal and blink only advance on the text screens.
    assign text_tick   = frame_tick && is_text_screen(screen_reg);

    frame_divider #(.N(REVEAL_FRAMES)) u_reveal_div (
        .clk      (clk),
        .rst      (rst),
        .clr      (enter_text),
        .tick_in  (text_tick),
        .tick_out (reveal_tick)
    );

    frame_divider #(.N(BLINK_FRAMES)) u_blink_div (
        .clk      (clk),
        .rst      (rst),
        .clr      (enter_text),
        .tick_in  (text_tick),
        .tick_out (blink_tick)
    );

    always_comb begin
        screen_next = screen_reg;
        skip        = 1'b0;
        unique case (screen_reg)
            SCR_START: begin
                if (start_press) begin
                    if (revealed) screen_next = SCR_PLAY;
                    else          skip        = 1'b1;
                end
            end
            SCR_PLAY: begin
                if (game_over) screen_next = SCR_END;
            end
            SCR_END: begin
                if (start_press) begin
                    if (revealed) screen_next = SCR_START;
                    else          skip        = 1'b1;
                end
            end
            default: screen_next = SCR_START;
        endcase

        enter_text = (screen_next != screen_reg) && is_text_screen(screen_next);

        // Entering a text screen restarts everything (a same-cycle frame tick
        // is lost); a skip beats a same-cycle reveal step.
        reveal_cnt_next = reveal_cnt_reg;
        if (enter_text) begin
            reveal_cnt_next = '0;
        end else if (skip) begin
            reveal_cnt_next = REVEAL_DONE;
        end else if (reveal_tick && !revealed) begin
            reveal_cnt_next = reveal_cnt_reg + 9'd1;
        end

        blink_next = blink_reg;
        if (enter_text) begin
            blink_next = 1'b1;
        end else if (blink_tick) begin
            blink_next = !blink_reg;
        end

        // Code is chosen from the post-edge state so the first code of a new
        // screen lands on the same edge as the state change.
        if (screen_next == SCR_PLAY) begin
            char_code_next = Spc;
        end else if ({1'b0, char_xy} >= reveal_cnt_next) begin
            char_code_next = Spc;
        end else if ((char_xy[7:4] == 4'hF) && !blink_next) begin
            char_code_next = Spc;
        end else if (screen_next == SCR_END) begin
            char_code_next = code_end;
        end else begin
            char_code_next = code_start;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_prev_reg  <= 1'b0;
            start_prev_reg  <= 1'b0;
            start_armed_reg <= 1'b0;
            screen_reg      <= SCR_START;
            reveal_cnt_reg  <= '0;
            blink_reg       <= 1'b1;
            char_code_reg   <= Spc;
            text_en_reg     <= 1'b0;
            game_active_reg <= 1'b0;
        end else begin
            vblnk_prev_reg  <= vblnk;
            start_prev_reg  <= start_btn;
            if (!start_btn) start_armed_reg <= 1'b1;
            screen_reg      <= screen_next;
            reveal_cnt_reg  <= reveal_cnt_next;
            blink_reg       <= blink_next;
            char_code_reg   <= char_code_next;
            text_en_reg     <= is_text_screen(screen_next);
            game_active_reg <= (screen_next == SCR_PLAY);
        end
    end

    assign char_code   = char_code_reg;
    assign text_en     = text_en_reg;
    assign game_active = game_active_reg;
    assign screen      = screen_reg;

endmodule
